aes_inv_cipher_iter: RTL
========================

Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher. One round is computed per clock for AES-128, AES-192 and AES-256, with the key length selected per block at run time.
- Owns its own round counter and FSM, with a start/ready handshake.
- Requests round keys from an external key-schedule/key-RAM by round index.
- Sits between the ciphertext source and the plaintext sink, next to the shared key expansion unit.

Parameters:
- BLOCK_LENGTH, 128, datapath/state width; only 128 is legal (elaboration error otherwise).
- RK_IDX_W, 4, width of the round-key index output; must be at least 4.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset, asynchronous, active-low.
- start  input  1  request to decrypt CT; accepted only when ready=1.
- ready  output  1  high in IDLE; core can accept start.
- key_len  input  2  sampled with start: 00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14); 11 is treated as 10.
- CT  input  BLOCK_LENGTH  ciphertext; sampled with start.
- rk_idx  output  RK_IDX_W  index of the round key needed in the current cycle (Nr down to 0).
- K_i  input  BLOCK_LENGTH  round key for rk_idx; combinational, same cycle.
- PT  output  BLOCK_LENGTH  plaintext; holds its value until the next completion.
- Valid  output  1  one-cycle pulse when PT is updated.
- busy  output  1  high while in ROUND.

Behaviour:
- Reset: state=IDLE, state register=0, PT=0, Valid=0, ready=1, busy=0, rk_idx=0, Nr register=10.
- FSM states: IDLE, ROUND.
- IDLE:
  - start=1 loads the state register with CT, latches Nr from key_len and sets round counter=Nr.
  - Moves to ROUND.
  - start while ready=0 is ignored; no queuing.
- ROUND (rk_idx = round counter). Each cycle, X = state ^ K_i, then:
  - First round (counter==Nr): state <= InvSubBytes(InvShiftRows(X)).
  - Middle rounds (0<counter<Nr): state <= InvSubBytes(InvShiftRows(InvMixColumns(X))).
  - Final round (counter==0): PT <= X; Valid <= 1 for one cycle; go to IDLE.
  - Counter decrements by 1 per ROUND cycle and never wraps below 0.
- Latency:
  - Nr+1 ROUND cycles follow the load edge.
  - Valid is high in the cycle after the final-round edge: 12/14/16 clocks after the start-sampling edge for AES-128/192/256.
  - ready returns high in the same cycle Valid is high.
  - Throughput: back-to-back start is legal in the Valid cycle.
- key_len and CT changes during ROUND have no effect.
- PT is unaffected by a new start until that block completes.
- rk_idx is held at 0 in IDLE.
- Reset mid-operation: immediate return to reset values; no Valid is issued for the aborted block.

Optional Feature:
- Macro: AES_DEC_KEY_STALL_EN.
- Defined:
  - Adds input port rk_valid (1 bit).
  - In ROUND, the state register, counter and PT update only when rk_valid=1; otherwise everything holds and rk_idx stays stable.
  - Latency grows by the number of stall cycles.
  - IDLE behaviour is unchanged.
- Undefined: no rk_valid port; K_i is treated as always valid (fixed latency as above).

Decomposition:
- Shared package aes_pkg:
  - key_len encodings KL_128/KL_192/KL_256.
  - Nr constants NR_128=10, NR_192=12, NR_256=14.
  - FSM state enum.
  - Inverse S-box and GF(2^8) xtime/multiply functions, reused by the encryption core.
- One sub-module: aes_inv_round_dp.
  - Purely combinational round datapath.
  - Inputs: state, key, first/final flags. Output: next state.
  - Wraps AddRoundKey, InvMixColumns, InvShiftRows and InvSubBytes.
  - Top level keeps only the FSM, counter and registers.

Test Plan (bench supplies FIPS-197 expanded keys indexed by rk_idx; key bytes 000102..1f):
- AES-128: CT=69c4e0d86a7b0430d8cdb78070b4c55a, key_len=00 -> PT=00112233445566778899aabbccddeeff; Valid 12 clocks after start; rk_idx sequence 10..0.
- AES-192: CT=dda97ca4864cdfe06eaf70a0ec0d7191, key_len=01 -> same PT; Valid at 14 clocks.
- AES-256: CT=8ea2b7ca516745bfeafc49904b496089, key_len=10 -> same PT; Valid at 16 clocks; key_len=11 gives an identical result.
- Back-to-back: second start (AES-256) asserted in the first block's Valid cycle -> accepted; both PTs correct; start pulses during busy ignored; PT stable between Valid pulses.
- Reset asserted at round 5 -> all outputs return to reset values asynchronously; no Valid; next start decrypts correctly.
- Under AES_DEC_KEY_STALL_EN: rk_valid low for 3 random cycles -> rk_idx is held during each stall; AES-128 PT is still correct; Valid arrives at 15 clocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, round counts, FSM states and GF(2^8) helpers
// used by both the inverse and forward cipher cores.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse computed as a^254, which maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a6   = gf_mul(a3, a3);
        a12  = gf_mul(a6, a6);
        a15  = gf_mul(a12, a3);
        a30  = gf_mul(a15, a15);
        a60  = gf_mul(a30, a30);
        a120 = gf_mul(a60, a60);
        a240 = gf_mul(a120, a120);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    // Inverse affine transform followed by field inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [3:0] nr_for(input logic [1:0] kl);
        case (kl)
            KL_128:  return NR_128;
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_256;
        endcase
    endfunction

endpackage

// File: rtl/aes_inv_round_dp.sv
// Combinational inverse round: AddRoundKey, then InvMixColumns (middle rounds only),
// InvShiftRows and InvSubBytes; the final round passes the keyed state straight through.
module aes_inv_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] key,
    input  logic         first_rnd,
    input  logic         last_rnd,
    output logic [127:0] state_next
);

    logic [127:0] x;
    logic [127:0] mixed;
    logic [127:0] pre;

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    assign x     = state ^ key;
    assign mixed = {inv_mix_col(x[127:96]), inv_mix_col(x[95:64]),
                    inv_mix_col(x[63:32]),  inv_mix_col(x[31:0])};
    assign pre   = first_rnd ? x : mixed;

    // Byte i sits at row i%4, column i/4; InvShiftRows pulls from column (c - r) mod 4.
    for (genvar i = 0; i < 16; i++) begin : g_byte
        localparam int ROW = i % 4;
        localparam int SRC = ROW + 4 * (((i / 4) + 4 - ROW) % 4);
        assign state_next[127-8*i -: 8] = last_rnd ? x[127-8*i -: 8]
                                                   : inv_sbox(pre[127-8*SRC -: 8]);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher, one round per clock, round keys fetched by index.
// Optional AES_DEC_KEY_STALL_EN adds rk_valid; ROUND progress then waits for a valid key.
//   state | meaning
//   IDLE  | ready for start, rk_idx held at 0
//   ROUND | one inverse round per clock, rk_idx = round counter (Nr down to 0)
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128,
    parameter int RK_IDX_W     = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    output logic                    ready,
    input  logic [1:0]              key_len,
    input  logic [BLOCK_LENGTH-1:0] CT,
    output logic [RK_IDX_W-1:0]     rk_idx,
    input  logic [BLOCK_LENGTH-1:0] K_i,
`ifdef AES_DEC_KEY_STALL_EN
    input  logic                    rk_valid,
`endif
    output logic [BLOCK_LENGTH-1:0] PT,
    output logic                    Valid,
    output logic                    busy
);

    if (BLOCK_LENGTH != 128) begin : g_bad_block_length
        $error("aes_inv_cipher_iter: BLOCK_LENGTH must be 128");
    end
    if (RK_IDX_W < 4) begin : g_bad_rk_idx_w
        $error("aes_inv_cipher_iter: RK_IDX_W must be at least 4");
    end

    state_t                  state_q, state_d;
    logic [RK_IDX_W-1:0]     cnt_q, cnt_d;
    logic [3:0]              nr_q, nr_d;
    logic [BLOCK_LENGTH-1:0] blk_q, blk_d;
    logic [BLOCK_LENGTH-1:0] pt_q, pt_d;
    logic                    valid_q, valid_d;
    logic [BLOCK_LENGTH-1:0] dp_out;
    logic                    first_rnd;
    logic                    last_rnd;
    logic                    rk_ok;

`ifdef AES_DEC_KEY_STALL_EN
    assign rk_ok = rk_valid;
`else
    assign rk_ok = 1'b1;
`endif

    assign first_rnd = (cnt_q == RK_IDX_W'(nr_q));
    assign last_rnd  = (cnt_q == '0);

    aes_inv_round_dp u_round_dp (
        .state      (blk_q),
        .key        (K_i),
        .first_rnd  (first_rnd),
        .last_rnd   (last_rnd),
        .state_next (dp_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        blk_d   = blk_q;
        pt_d    = pt_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nr_d    = nr_for(key_len);
                    cnt_d   = RK_IDX_W'(nr_for(key_len));
                    blk_d   = CT;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                if (rk_ok) begin
                    if (last_rnd) begin
                        pt_d    = dp_out;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        blk_d = dp_out;
                        cnt_d = cnt_q - RK_IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            nr_q    <= NR_128;
            blk_q   <= '0;
            pt_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nr_q    <= nr_d;
            blk_q   <= blk_d;
            pt_q    <= pt_d;
            valid_q <= valid_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_ROUND);
    assign rk_idx = (state_q == ST_ROUND) ? cnt_q : '0;
    assign PT     = pt_q;
    assign Valid  = valid_q;

endmodule
